qdrc_phy_train_pattern: RTL

Training-traffic initiator for the QDR PHY calibration path. It writes a fixed pattern into two SRAM locations, then reads address 0 back-to-back while the per-bit IODELAY trainer calibrates. After the trainer finishes, it runs a read-compare pass over both locations to confirm the calibrated data path. It sits between the QDR controller's command/data mux and the PHY, on the transmit side of the bit-training loop.

---
 rtl/qdrc_phy_pkg.sv | 27 ++
 rtl/qdrc_rd_expect_pipe.sv | 35 +++
 rtl/qdrc_phy_train_pattern.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/qdrc_phy_pkg.sv
// Shared definitions for the QDR PHY training-traffic path: state encoding
// and the two fixed write/compare patterns.
package qdrc_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READ   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } train_state_t;

  // Patterns are built at the widest supported bus and cast down by the user.
  localparam int PAT_MAX_W = 64;

  // addr_bit 0 selects pattern A (rise all 1s), 1 selects pattern B (rise all 0s).
  function automatic logic [PAT_MAX_W-1:0] pat_rise(input logic addr_bit);
    return addr_bit ? {PAT_MAX_W{1'b0}} : {PAT_MAX_W{1'b1}};
  endfunction

  function automatic logic [PAT_MAX_W-1:0] pat_fall(input logic addr_bit);
    return addr_bit ? {PAT_MAX_W{1'b1}} : {PAT_MAX_W{1'b0}};
  endfunction

endpackage

// File: rtl/qdrc_rd_expect_pipe.sv
// Fixed-depth valid+tag shift register tracking outstanding reads; an entry
// pushed in cycle T pops in cycle T+DEPTH. No backpressure; clear empties it.
module qdrc_rd_expect_pipe #(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic push,
  input  logic push_tag,
  output logic pop_vld,
  output logic pop_tag
);

  logic [DEPTH-1:0] vld_sr;
  logic [DEPTH-1:0] tag_sr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vld_sr <= '0;
      tag_sr <= '0;
    end else begin
      vld_sr[0] <= push;
      tag_sr[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  assign pop_vld = vld_sr[DEPTH-1];
  assign pop_tag = tag_sr[DEPTH-1];

endmodule

// File: rtl/qdrc_phy_train_pattern.sv
// Training-traffic initiator: writes patterns A/B, streams reads for the bit
// trainer, then read-compares both locations. Outputs registered, 1-cycle start latency.
module qdrc_phy_train_pattern
  import qdrc_phy_pkg::*;
#(
  parameter int DATA_WIDTH  = 36,
  parameter int ADDR_WIDTH  = 21,
  parameter int WR_SETTLE   = 16,
  parameter int RD_LATENCY  = 10,
  parameter int CHECK_READS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  train_start,
  input  logic                  bit_train_done,
  input  logic                  bit_train_fail,
  input  logic [DATA_WIDTH-1:0] q_rise,
  input  logic [DATA_WIDTH-1:0] q_fall,
  output logic [ADDR_WIDTH-1:0] qdr_sa,
  output logic                  qdr_w_n,
  output logic                  qdr_r_n,
  output logic [DATA_WIDTH-1:0] qdr_d_rise,
  output logic [DATA_WIDTH-1:0] qdr_d_fall,
  output logic [3:0]            qdr_bw_n,
  output logic                  reads_active,
  output logic                  train_done,
  output logic                  train_fail,
  output logic [2:0]            state_prb
);

  train_state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [7:0] chk_cnt, chk_cnt_nxt;
  logic       wr_phase, wr_phase_nxt;

  logic [ADDR_WIDTH-1:0] sa_nxt;
  logic                  w_n_nxt, r_n_nxt;
  logic [DATA_WIDTH-1:0] d_rise_nxt, d_fall_nxt;
  logic [3:0]            bw_n_nxt;

  logic [DATA_WIDTH-1:0] pat_a_rise, pat_a_fall, pat_b_rise, pat_b_fall;
  assign pat_a_rise = DATA_WIDTH'(pat_rise(1'b0));
  assign pat_a_fall = DATA_WIDTH'(pat_fall(1'b0));
  assign pat_b_rise = DATA_WIDTH'(pat_rise(1'b1));
  assign pat_b_fall = DATA_WIDTH'(pat_fall(1'b1));

  logic                  pop_vld, pop_tag;
  logic [DATA_WIDTH-1:0] exp_rise, exp_fall, diff;
  logic                  cmp_err;
  logic [5:0]            err_idx;
  logic [5:0]            dbg_fail_idx;
  logic                  mism_seen;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    chk_cnt_nxt  = chk_cnt;
    wr_phase_nxt = 1'b0;
    case (state)
      ST_IDLE:   if (train_start) state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (wr_phase) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end else begin
          wr_phase_nxt = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (int'(cnt) >= WR_SETTLE - 1) state_nxt = ST_READ;
        else                            cnt_nxt   = cnt + 5'd1;
      end
      ST_READ: begin
        if (bit_train_done) begin
          state_nxt   = bit_train_fail ? ST_DONE : ST_CHECK;
          chk_cnt_nxt = '0;
        end
      end
      ST_CHECK: begin
        if (chk_cnt == 8'(CHECK_READS - 1)) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end else begin
          chk_cnt_nxt = chk_cnt + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (int'(cnt) >= RD_LATENCY - 1) state_nxt = ST_DONE;
        else                             cnt_nxt   = cnt + 5'd1;
      end
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase

    // Pin values are decoded from the next state so they line up with state_prb.
    sa_nxt     = '0;
    w_n_nxt    = 1'b1;
    r_n_nxt    = 1'b1;
    bw_n_nxt   = 4'hF;
    d_rise_nxt = pat_a_rise;
    d_fall_nxt = pat_a_fall;
    case (state_nxt)
      ST_WRITE: begin
        w_n_nxt    = 1'b0;
        bw_n_nxt   = 4'h0;
        sa_nxt     = ADDR_WIDTH'(wr_phase_nxt);
        d_rise_nxt = wr_phase_nxt ? pat_b_rise : pat_a_rise;
        d_fall_nxt = wr_phase_nxt ? pat_b_fall : pat_a_fall;
      end
      ST_READ:  r_n_nxt = 1'b0;
      ST_CHECK: begin
        r_n_nxt = 1'b0;
        sa_nxt  = ADDR_WIDTH'(chk_cnt_nxt[0]);
      end
      default: ;
    endcase
  end

  // Only CHECK reads are tracked; returns from trainer reads never reach the comparator.
  qdrc_rd_expect_pipe #(.DEPTH(RD_LATENCY)) u_expect (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_IDLE),
    .push     (state == ST_CHECK),
    .push_tag (qdr_sa[0]),
    .pop_vld  (pop_vld),
    .pop_tag  (pop_tag)
  );

  assign exp_rise = pop_tag ? pat_b_rise : pat_a_rise;
  assign exp_fall = pop_tag ? pat_b_fall : pat_a_fall;
  assign diff     = (q_rise ^ exp_rise) | (q_fall ^ exp_fall);
  assign cmp_err  = pop_vld && (diff != '0);

  always_comb begin
    err_idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) err_idx = 6'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      chk_cnt      <= '0;
      wr_phase     <= 1'b0;
      qdr_sa       <= '0;
      qdr_w_n      <= 1'b1;
      qdr_r_n      <= 1'b1;
      qdr_bw_n     <= 4'hF;
      qdr_d_rise   <= pat_a_rise;
      qdr_d_fall   <= pat_a_fall;
      reads_active <= 1'b0;
      train_done   <= 1'b0;
      train_fail   <= 1'b0;
      dbg_fail_idx <= '0;
      mism_seen    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      chk_cnt      <= chk_cnt_nxt;
      wr_phase     <= wr_phase_nxt;
      qdr_sa       <= sa_nxt;
      qdr_w_n      <= w_n_nxt;
      qdr_r_n      <= r_n_nxt;
      qdr_bw_n     <= bw_n_nxt;
      qdr_d_rise   <= d_rise_nxt;
      qdr_d_fall   <= d_fall_nxt;
      reads_active <= (state_nxt == ST_READ);
      train_done   <= (state_nxt == ST_DONE);
      if ((state == ST_READ && bit_train_done && bit_train_fail) || cmp_err)
        train_fail <= 1'b1;
      if (cmp_err && !mism_seen) begin
        mism_seen    <= 1'b1;
        dbg_fail_idx <= err_idx;
      end
    end
  end

  assign state_prb = state;

endmodule
